// File: rtl/eth_serdes_rx_slip.sv
// rtl/eth_serdes_rx_slip.sv - bitslip responder aligning raw transceiver words for the 10G PHY receiver (optional stats: ETH_SERDES_RX_SLIP_STATS_EN)

module eth_serdes_rx_slip #(
    parameter int FRAME_WIDTH        = 66,
    parameter int OFFSET_WIDTH       = 7,
    parameter int SLIP_SETTLE_CYCLES = 4,
    parameter int RESET_HOLD_CYCLES  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [FRAME_WIDTH-1:0]  gt_rx_data,
    input  logic                    gt_rx_valid,
    output logic [FRAME_WIDTH-1:0]  serdes_rx,
    output logic                    serdes_rx_valid,
    input  logic                    serdes_rx_bitslip,
    input  logic                    serdes_rx_reset_req,
    output logic [OFFSET_WIDTH-1:0] slip_offset,
    output logic                    slip_busy
`ifdef ETH_SERDES_RX_SLIP_STATS_EN
    ,
    output logic [15:0]             slip_count,
    output logic [0:0]              slip_wrap
`endif
);

    localparam int SETTLE_W = $clog2(SLIP_SETTLE_CYCLES + 1);
    localparam int HOLD_W   = $clog2(RESET_HOLD_CYCLES + 1);
    localparam logic [OFFSET_WIDTH-1:0] LAST_OFFSET = OFFSET_WIDTH'(FRAME_WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_HOLD
    } state_t;

    state_t                  state_q, state_d;
    logic [OFFSET_WIDTH-1:0] offset_q, offset_d;
    logic [SETTLE_W-1:0]     settle_q, settle_d;
    logic [HOLD_W-1:0]       hold_q, hold_d;
    logic                    bitslip_q;
    logic [FRAME_WIDTH-1:0]  prev_q, cur_q;
    logic [FRAME_WIDTH-1:0]  rx_data_q;
    logic                    rx_valid_q;
    logic                    slip_edge;
    logic                    blank;
    logic [FRAME_WIDTH-1:0]  window;

    assign slip_edge = serdes_rx_bitslip & ~bitslip_q;
    // The output stays blanked on the cycle the reset request arrives and for
    // every cycle the FSM sits in HOLD, including the one it leaves HOLD on.
    assign blank     = serdes_rx_reset_req | (state_q == ST_HOLD);
    // Offset 0 selects prev as-is; higher offsets pull bits in from cur.
    assign window    = FRAME_WIDTH'({cur_q, prev_q} >> offset_q);

    // Next-state logic: reset request overrides everything, slips only accepted in IDLE
    always_comb begin
        state_d  = state_q;
        offset_d = offset_q;
        settle_d = settle_q;
        hold_d   = hold_q;
        if (serdes_rx_reset_req) begin
            state_d  = ST_HOLD;
            offset_d = '0;
            settle_d = '0;
            hold_d   = HOLD_W'(RESET_HOLD_CYCLES);
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (slip_edge) begin
                        offset_d = (offset_q == LAST_OFFSET) ? '0 : offset_q + OFFSET_WIDTH'(1);
                        settle_d = SETTLE_W'(SLIP_SETTLE_CYCLES);
                        state_d  = ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (settle_q <= SETTLE_W'(1)) begin
                        settle_d = '0;
                        state_d  = ST_IDLE;
                    end else begin
                        settle_d = settle_q - SETTLE_W'(1);
                    end
                end
                ST_HOLD: begin
                    if (hold_q <= HOLD_W'(1)) begin
                        hold_d  = '0;
                        state_d = ST_IDLE;
                    end else begin
                        hold_d = hold_q - HOLD_W'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // FSM, offset, counters and bitslip edge history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            offset_q  <= '0;
            settle_q  <= '0;
            hold_q    <= '0;
            bitslip_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            offset_q  <= offset_d;
            settle_q  <= settle_d;
            hold_q    <= hold_d;
            bitslip_q <= serdes_rx_bitslip;
        end
    end

    // Two-word shift buffer and registered window output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q     <= '0;
            cur_q      <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            if (gt_rx_valid) begin
                prev_q <= cur_q;
                cur_q  <= gt_rx_data;
            end
            rx_data_q  <= blank ? '0 : window;
            rx_valid_q <= blank ? 1'b0 : gt_rx_valid;
        end
    end

    assign serdes_rx       = rx_data_q;
    assign serdes_rx_valid = rx_valid_q;
    assign slip_offset     = offset_q;
    assign slip_busy       = (state_q != ST_IDLE);

`ifdef ETH_SERDES_RX_SLIP_STATS_EN
    logic        slip_accept;
    logic [15:0] slip_count_q;
    logic        slip_wrap_q;

    assign slip_accept = (state_q == ST_IDLE) & slip_edge & ~serdes_rx_reset_req;

    // Saturating accepted-slip counter and wrap pulse; cleared by a reset request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slip_count_q <= '0;
            slip_wrap_q  <= 1'b0;
        end else begin
            slip_wrap_q <= slip_accept & (offset_q == LAST_OFFSET);
            if (serdes_rx_reset_req) begin
                slip_count_q <= '0;
            end else if (slip_accept && slip_count_q != 16'hFFFF) begin
                slip_count_q <= slip_count_q + 16'd1;
            end
        end
    end

    assign slip_count = slip_count_q;
    assign slip_wrap  = slip_wrap_q;
`endif

endmodule

// File: tb/tb_eth_serdes_rx_slip.sv
// tb/tb_eth_serdes_rx_slip.sv - scoreboard bench for eth_serdes_rx_slip (stats checks under ETH_SERDES_RX_SLIP_STATS_EN)

module tb_eth_serdes_rx_slip;

    logic        clk;
    logic        rst_n;
    logic [65:0] gt_rx_data;
    logic        gt_rx_valid;
    logic [65:0] serdes_rx;
    logic        serdes_rx_valid;
    logic        serdes_rx_bitslip;
    logic        serdes_rx_reset_req;
    logic [6:0]  slip_offset;
    logic        slip_busy;
`ifdef ETH_SERDES_RX_SLIP_STATS_EN
    logic [15:0] slip_count;
    logic [0:0]  slip_wrap;
`endif

    int checks = 0;
    int failures = 0;
    int exp_off = 0;
    int wraps = 0;
    logic [65:0] bw_cur = '0;
    logic [65:0] bw_prev = '0;
    logic [65:0] exp_data_q[$];
    logic        exp_valid_q[$];

    eth_serdes_rx_slip dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .gt_rx_data          (gt_rx_data),
        .gt_rx_valid         (gt_rx_valid),
        .serdes_rx           (serdes_rx),
        .serdes_rx_valid     (serdes_rx_valid),
        .serdes_rx_bitslip   (serdes_rx_bitslip),
        .serdes_rx_reset_req (serdes_rx_reset_req),
        .slip_offset         (slip_offset),
        .slip_busy           (slip_busy)
`ifdef ETH_SERDES_RX_SLIP_STATS_EN
        ,
        .slip_count          (slip_count),
        .slip_wrap           (slip_wrap)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [65:0] rnd();
        logic [95:0] t;
        t = {$urandom(), $urandom(), $urandom()};
        return t[65:0];
    endfunction

    // Reference window: bit b of the output is bit (b+off) of the 132-bit {cur,prev} stream
    function automatic logic [65:0] win(input logic [65:0] c, input logic [65:0] p, input int off);
        logic [131:0] s;
        logic [65:0]  r;
        s = {c, p};
        for (int b = 0; b < 66; b++) r[b] = s[b + off];
        return r;
    endfunction

    // One clock: drive a word, push the expected output, then pop and compare
    task automatic step(input logic [65:0] d, input logic v, input logic blank);
        gt_rx_data  = d;
        gt_rx_valid = v;
        exp_data_q.push_back(blank ? 66'h0 : win(bw_cur, bw_prev, exp_off));
        exp_valid_q.push_back(blank ? 1'b0 : v);
        @(posedge clk);
        #1;
        if (v) begin
            bw_prev = bw_cur;
            bw_cur  = d;
        end
        chk("serdes_rx", serdes_rx, exp_data_q.pop_front());
        chk("serdes_rx_valid", 66'(serdes_rx_valid), 66'(exp_valid_q.pop_front()));
`ifdef ETH_SERDES_RX_SLIP_STATS_EN
        if (slip_wrap == 1'b1) wraps++;
`endif
    endtask

    task automatic slip_one();
        serdes_rx_bitslip = 1'b1;
        step(rnd(), 1'b1, 1'b0);
        exp_off = (exp_off == 65) ? 0 : exp_off + 1;
        chk("slip_offset", 66'(slip_offset), 66'(exp_off));
        serdes_rx_bitslip = 1'b0;
        repeat (8) step(rnd(), 1'b1, 1'b0);
    endtask

    initial begin
        rst_n               = 1'b0;
        gt_rx_data          = '0;
        gt_rx_valid         = 1'b0;
        serdes_rx_bitslip   = 1'b0;
        serdes_rx_reset_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_serdes_rx", serdes_rx, 66'h0);
        chk("rst_valid", 66'(serdes_rx_valid), 66'h0);
        chk("rst_offset", 66'(slip_offset), 66'h0);
        chk("rst_busy", 66'(slip_busy), 66'h0);
        rst_n = 1'b1;

        // Offset 0 alignment: W0 appears two valid cycles later
        step(66'h1, 1'b1, 1'b0);
        step(66'h2, 1'b1, 1'b0);
        step(rnd(), 1'b1, 1'b0);
        chk("align_w0", serdes_rx, 66'h1);
        step(rnd(), 1'b1, 1'b0);
        chk("align_w1", serdes_rx, 66'h2);
        repeat (4) step(rnd(), 1'b1, 1'b0);
        step(rnd(), 1'b0, 1'b0);

        // Single slip with gt_rx_valid low; {cur,prev} = {0, 2}
        step(66'h2, 1'b1, 1'b0);
        step(66'h0, 1'b1, 1'b0);
        serdes_rx_bitslip = 1'b1;
        step(rnd(), 1'b0, 1'b0);
        exp_off = 1;
        chk("slip1_offset", 66'(slip_offset), 66'd1);
        chk("slip1_busy_c1", 66'(slip_busy), 66'd1);
        serdes_rx_bitslip = 1'b0;
        step(rnd(), 1'b0, 1'b0);
        chk("slip1_window", serdes_rx, 66'h1);
        chk("slip1_busy_c2", 66'(slip_busy), 66'd1);
        step(rnd(), 1'b0, 1'b0);
        chk("slip1_busy_c3", 66'(slip_busy), 66'd1);
        step(rnd(), 1'b0, 1'b0);
        chk("slip1_busy_c4", 66'(slip_busy), 66'd1);
        step(rnd(), 1'b0, 1'b0);
        chk("slip1_busy_done", 66'(slip_busy), 66'd0);

        // Settle rejection: edge 2 cycles later ignored, edge 5 cycles later accepted
        serdes_rx_bitslip = 1'b1;
        step(rnd(), 1'b1, 1'b0);
        exp_off = 2;
        serdes_rx_bitslip = 1'b0;
        step(rnd(), 1'b1, 1'b0);
        serdes_rx_bitslip = 1'b1;
        step(rnd(), 1'b1, 1'b0);
        chk("settle_ignored", 66'(slip_offset), 66'd2);
        serdes_rx_bitslip = 1'b0;
        step(rnd(), 1'b1, 1'b0);
        step(rnd(), 1'b1, 1'b0);
        serdes_rx_bitslip = 1'b1;
        step(rnd(), 1'b1, 1'b0);
        exp_off = 3;
        chk("settle_accepted", 66'(slip_offset), 66'd3);
        serdes_rx_bitslip = 1'b0;
        repeat (8) step(rnd(), 1'b1, 1'b0);

        // Walk to offset 10, then reset request with a simultaneous slip edge
        repeat (7) slip_one();
        chk("pre_reset_offset", 66'(slip_offset), 66'd10);
        serdes_rx_bitslip   = 1'b1;
        serdes_rx_reset_req = 1'b1;
        step(rnd(), 1'b1, 1'b1);
        exp_off = 0;
        chk("reset_offset", 66'(slip_offset), 66'd0);
        chk("reset_busy", 66'(slip_busy), 66'd1);
        serdes_rx_bitslip = 1'b0;
        repeat (2) step(rnd(), 1'b1, 1'b1);
        serdes_rx_reset_req = 1'b0;
        repeat (16) step(rnd(), 1'b1, 1'b1);
        step(rnd(), 1'b1, 1'b0);
        chk("hold_done_valid", 66'(serdes_rx_valid), 66'd1);
        chk("hold_done_busy", 66'(slip_busy), 66'd0);
`ifdef ETH_SERDES_RX_SLIP_STATS_EN
        chk("count_cleared", 66'(slip_count), 66'd0);
`endif

        // Wrap: 66 spaced slips return to offset 0
        wraps = 0;
        repeat (66) slip_one();
        chk("wrap_offset", 66'(slip_offset), 66'd0);
`ifdef ETH_SERDES_RX_SLIP_STATS_EN
        chk("wrap_count", 66'(slip_count), 66'd66);
        chk("wrap_pulses", 66'(wraps), 66'd1);
`endif

        // Async reset mid-SETTLE
        serdes_rx_bitslip = 1'b1;
        step(rnd(), 1'b1, 1'b0);
        exp_off = 1;
        serdes_rx_bitslip = 1'b0;
        chk("pre_async_busy", 66'(slip_busy), 66'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_serdes_rx", serdes_rx, 66'h0);
        chk("async_valid", 66'(serdes_rx_valid), 66'd0);
        chk("async_offset", 66'(slip_offset), 66'd0);
        chk("async_busy", 66'(slip_busy), 66'd0);
`ifdef ETH_SERDES_RX_SLIP_STATS_EN
        chk("async_count", 66'(slip_count), 66'd0);
`endif
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        bw_cur  = '0;
        bw_prev = '0;
        exp_off = 0;
        repeat (3) step(rnd(), 1'b1, 1'b0);
        slip_one();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
